// File: rtl/dtree_pkg.sv
// Shared types and helpers for the decision-tree feature sequencer.
// Holds the sequencer state encoding, default widths and the saturating increment.
package dtree_pkg;

  typedef enum logic [1:0] {LOAD, LABEL, SETTLE, RESULT} state_t;

  localparam int DEF_FEAT_W       = 8;
  localparam int DEF_NUM_FEATURES = 5;
  localparam int SAT_MAX_W        = 32;

  // Increment v unless it already holds the all-ones value of a w-bit counter.
  function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] v, input int w);
    logic [SAT_MAX_W-1:0] lim;
    lim = {SAT_MAX_W{1'b1}} >> (SAT_MAX_W - w);
    return (v == lim) ? v : v + SAT_MAX_W'(1);
  endfunction

endpackage

// File: rtl/dtree_sat_counter.sv
// Saturating statistics counter; clear beats increment on the same cycle.
// One-cycle update, never wraps past all-ones.
module sat_counter
  import dtree_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= CNT_W'(sat_inc(SAT_MAX_W'(cnt), CNT_W));
    end
  end

endmodule

// File: rtl/dtree_feature_sequencer.sv
// Byte-stream front end and result back end for a combinational decision tree.
// Result valid SETTLE_CYCLES+1 after the last byte; input stalls until the result is taken.
module dtree_feature_sequencer
  import dtree_pkg::*;
#(
  parameter int NUM_FEATURES  = DEF_NUM_FEATURES,
  parameter int FEAT_W        = DEF_FEAT_W,
  parameter int CLASS_W       = 1,
  parameter int SETTLE_CYCLES = 2,
  parameter int HAS_LABEL     = 1,
  parameter int CNT_W         = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic [FEAT_W-1:0]              in_data,
  output logic                           in_ready,
  output logic [NUM_FEATURES*FEAT_W-1:0] feat_bus,
  input  logic [CLASS_W-1:0]             tree_class,
  output logic                           res_valid,
  output logic [CLASS_W-1:0]             res_class,
  output logic                           res_correct,
  input  logic                           res_ready,
  input  logic                           clr_stats,
  output logic [CNT_W-1:0]               sample_cnt,
  output logic [CNT_W-1:0]               correct_cnt
);

  localparam int IDX_W = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;

  state_t                         state, state_nxt;
  logic [IDX_W-1:0]               idx;
  logic [NUM_FEATURES*FEAT_W-1:0] feat_q;
  logic [CLASS_W-1:0]             label_q;
  logic [3:0]                     settle_cnt;
  logic                           accept;
  logic                           last_feat;
  logic                           capture;
  logic                           is_match;

  assign accept    = in_valid && in_ready;
  assign last_feat = (idx == IDX_W'(NUM_FEATURES - 1));
  assign capture   = (state == SETTLE) && (settle_cnt == 4'd0);
  assign is_match  = (HAS_LABEL != 0) && (tree_class == label_q);
  assign feat_bus  = feat_q;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (accept && last_feat) state_nxt = (HAS_LABEL != 0) ? LABEL : SETTLE;
      end
      LABEL: begin
        in_ready = 1'b1;
        if (accept) state_nxt = SETTLE;
      end
      SETTLE: begin
        if (settle_cnt == 4'd0) state_nxt = RESULT;
      end
      RESULT: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= LOAD;
      idx         <= '0;
      feat_q      <= '0;
      label_q     <= '0;
      settle_cnt  <= '0;
      res_class   <= '0;
      res_correct <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == LOAD && accept) begin
        feat_q[int'(idx)*FEAT_W +: FEAT_W] <= in_data;
        idx <= last_feat ? '0 : idx + IDX_W'(1);
      end
      if (state == LABEL && accept) label_q <= in_data[CLASS_W-1:0];
      // Counter is loaded on entry so SETTLE lasts exactly SETTLE_CYCLES cycles.
      if (state != SETTLE && state_nxt == SETTLE) begin
        settle_cnt <= 4'(SETTLE_CYCLES - 1);
      end else if (state == SETTLE && settle_cnt != 4'd0) begin
        settle_cnt <= settle_cnt - 4'd1;
      end
      if (capture) begin
        res_class   <= tree_class;
        res_correct <= is_match;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_sample_cnt (
    .clk (clk),
    .rst (rst),
    .inc (capture),
    .clr (clr_stats),
    .cnt (sample_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_correct_cnt (
    .clk (clk),
    .rst (rst),
    .inc (capture && is_match),
    .clr (clr_stats),
    .cnt (correct_cnt)
  );

endmodule
